// File: rtl/ddr3_user_test_master.sv
// Traffic generator/checker for the DDR3 user bridge: writes a burst
// pattern, reads it back, compares every beat and counts passes/errors.
module ddr3_user_test_master #(
  parameter int          BURST_LEN      = 64,
  parameter int          NUM_BURSTS     = 16,
  parameter logic [29:0] BASE_ADDR      = 30'h0,
  parameter int          TIMEOUT_CYCLES = 65535
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         u_wr_cmd_en,
  output logic [29:0]  u_wr_addr,
  output logic [6:0]   u_wr_len,
  output logic         u_wr_en,
  output logic [127:0] u_wr_data,
  input  logic         u_wr_rdy,
  input  logic         u_wr_cmd_done,
  output logic         u_rd_cmd_en,
  output logic [29:0]  u_rd_addr,
  output logic [6:0]   u_rd_len,
  output logic         u_rd_en,
  input  logic [127:0] u_rd_data,
  input  logic         u_rd_rdy,
  input  logic         u_rd_cmd_done,
  output logic         busy,
  output logic [15:0]  pass_cnt,
  output logic [15:0]  err_cnt,
  output logic         err_flag,
  output logic         timeout_flag
);

  typedef enum logic [2:0] {
    IDLE, WR_CMD, WR_DATA, WR_WAIT,
    RD_CMD, RD_DATA, RD_WAIT, NEXT
  } state_t;

  localparam logic [6:0]  BL       = 7'(BURST_LEN);
  localparam logic [8:0]  LAST_B   = 9'(NUM_BURSTS - 1);
  localparam logic [29:0] STRIDE   = 30'(BURST_LEN * 16);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  function automatic logic [127:0] pattern(
    input logic [7:0] p,
    input logic [8:0] b,
    input logic [6:0] k
  );
    logic [23:0] w;
    w = 24'(b) * 24'(BURST_LEN) + 24'(k);
    return {4{p, w}};
  endfunction

  state_t      state_q, state_d;
  logic [8:0]  b_q, b_d;
  logic [6:0]  beat_q, beat_d;
  logic [6:0]  cmp_q, cmp_d;
  logic        rd_en_q, rd_en_d;
  logic        rd_done_q, rd_done_d;
  logic [31:0] tmo_q, tmo_d;
  logic [15:0] pass_q, pass_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic        err_flag_q, err_flag_d;
  logic        tmo_flag_q, tmo_flag_d;

  logic        wr_fire;
  logic        rd_fire;
  logic        last_b;
  logic        mismatch;
  logic        counting;
  logic [29:0] burst_addr;

  assign wr_fire = (state_q == WR_DATA) && u_wr_rdy && (beat_q < BL);
  assign rd_fire = (state_q == RD_DATA) && u_rd_rdy && (beat_q < BL);
  assign last_b  = (b_q == LAST_B);
  assign burst_addr = BASE_ADDR + 30'(b_q) * STRIDE;
  assign counting = state_q inside {WR_DATA, WR_WAIT, RD_DATA, RD_WAIT};

  // rd_en_q marks the cycle the popped beat is visible on u_rd_data
  assign mismatch = rd_en_q &&
    (u_rd_data != pattern(pass_q[7:0], b_q, cmp_q));

  always_comb begin
    state_d    = state_q;
    b_d        = b_q;
    beat_d     = beat_q;
    cmp_d      = cmp_q;
    rd_en_d    = rd_fire;
    rd_done_d  = rd_done_q;
    tmo_d      = tmo_q;
    pass_d     = pass_q;
    err_cnt_d  = err_cnt_q;
    err_flag_d = err_flag_q;
    tmo_flag_d = tmo_flag_q;

    unique case (state_q)
      IDLE: begin
        b_d = '0;
        if (start) state_d = WR_CMD;
      end
      WR_CMD: begin
        beat_d  = '0;
        state_d = WR_DATA;
      end
      WR_DATA: begin
        if (wr_fire) begin
          beat_d = beat_q + 7'd1;
          if (beat_q == BL - 7'd1) state_d = WR_WAIT;
        end
      end
      WR_WAIT: begin
        if (u_wr_cmd_done) begin
          if (last_b) begin
            b_d     = '0;
            state_d = RD_CMD;
          end else begin
            b_d     = b_q + 9'd1;
            state_d = WR_CMD;
          end
        end
      end
      RD_CMD: begin
        beat_d    = '0;
        cmp_d     = '0;
        rd_done_d = 1'b0;
        state_d   = RD_DATA;
      end
      RD_DATA: begin
        if (rd_fire) beat_d = beat_q + 7'd1;
        if (u_rd_cmd_done) rd_done_d = 1'b1;
        if (rd_en_q) begin
          cmp_d = cmp_q + 7'd1;
          if (cmp_q == BL - 7'd1) state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (u_rd_cmd_done || rd_done_q) begin
          if (last_b) begin
            state_d = NEXT;
          end else begin
            b_d     = b_q + 9'd1;
            state_d = RD_CMD;
          end
        end
      end
      NEXT: begin
        if (pass_q != 16'hFFFF) pass_d = pass_q + 16'd1;
        b_d     = '0;
        state_d = start ? WR_CMD : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (mismatch) begin
      err_flag_d = 1'b1;
      if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
    end

    // Any progress (state change or beat) restarts the watchdog
    if ((state_d != state_q) || wr_fire || rd_fire) begin
      tmo_d = '0;
    end else if (counting) begin
      if (tmo_q == TMO_LAST) begin
        tmo_flag_d = 1'b1;
        tmo_d      = '0;
        state_d    = IDLE;
      end else begin
        tmo_d = tmo_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      b_q        <= '0;
      beat_q     <= '0;
      cmp_q      <= '0;
      rd_en_q    <= 1'b0;
      rd_done_q  <= 1'b0;
      tmo_q      <= '0;
      pass_q     <= '0;
      err_cnt_q  <= '0;
      err_flag_q <= 1'b0;
      tmo_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      b_q        <= b_d;
      beat_q     <= beat_d;
      cmp_q      <= cmp_d;
      rd_en_q    <= rd_en_d;
      rd_done_q  <= rd_done_d;
      tmo_q      <= tmo_d;
      pass_q     <= pass_d;
      err_cnt_q  <= err_cnt_d;
      err_flag_q <= err_flag_d;
      tmo_flag_q <= tmo_flag_d;
    end
  end

  assign u_wr_cmd_en  = (state_q == WR_CMD);
  assign u_wr_addr    = u_wr_cmd_en ? burst_addr : '0;
  assign u_wr_len     = u_wr_cmd_en ? BL : '0;
  assign u_wr_en      = wr_fire;
  assign u_wr_data    = pattern(pass_q[7:0], b_q, beat_q);
  assign u_rd_cmd_en  = (state_q == RD_CMD);
  assign u_rd_addr    = u_rd_cmd_en ? burst_addr : '0;
  assign u_rd_len     = u_rd_cmd_en ? BL : '0;
  assign u_rd_en      = rd_fire;
  assign busy         = (state_q != IDLE);
  assign pass_cnt     = pass_q;
  assign err_cnt      = err_cnt_q;
  assign err_flag     = err_flag_q;
  assign timeout_flag = tmo_flag_q;

endmodule
